// File: rtl/router_dst_reader.sv
// Destination-side reader for one router output port: parses header,
// payload and parity, and streams payload bytes through a small skid FIFO.
module router_dst_reader #(
  parameter int SKID_DEPTH  = 2,
  parameter int STALL_LIMIT = 25,
  parameter int GAP_LIMIT   = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       hdr_valid,
  output logic [5:0] hdr_len,
  output logic [1:0] hdr_addr,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       pkt_abort,
  output logic       stall_warn
);

  localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int GW = $clog2(GAP_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY
  } state_t;

  state_t state;

  logic          inflight;
  logic [7:0]    parity_acc;
  logic [5:0]    cnt;
  logic [8:0]    mem [SKID_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [SW-1:0] stall_cnt;
  logic [GW-1:0] gap_cnt;
  logic [OW:0]   pending;

  logic fire;
  logic cap;
  logic push;
  logic pop;
  logic gap_hit;
  logic last_byte;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A read is only issued when its byte is guaranteed a skid slot,
  // so header and parity reads are throttled the same way as payload.
  always_comb begin
    pending    = {1'b0, occ} + (OW + 1)'(inflight);
    read_enb   = !reset && vld_out &&
                 (pending < (OW + 1)'(SKID_DEPTH));
    fire       = read_enb;
    cap        = inflight;
    last_byte  = (cnt == hdr_len - 6'd1);
    push       = cap && (state == PAYLOAD);
    m_valid    = (occ != '0);
    pop        = m_valid && m_ready;
    m_data     = m_valid ? mem[rd_ptr][7:0] : 8'h00;
    m_last     = m_valid && mem[rd_ptr][8];
    gap_hit    = (state != IDLE) && !vld_out && !inflight &&
                 (gap_cnt == GW'(GAP_LIMIT - 1));
    stall_warn = (stall_cnt >= SW'(STALL_LIMIT));
  end

  always_ff @(posedge clock) begin
    if (reset || gap_hit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {last_byte, data_out};
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= 1'b0;
      parity_acc <= '0;
      cnt        <= '0;
      hdr_len    <= '0;
      hdr_addr   <= '0;
      hdr_valid  <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_abort  <= 1'b0;
      stall_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      inflight  <= fire;
      hdr_valid <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_abort <= 1'b0;

      if (vld_out && !read_enb) begin
        if (stall_cnt != SW'(STALL_LIMIT)) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        stall_cnt <= '0;
      end

      if (fire || state == IDLE || gap_hit) begin
        gap_cnt <= '0;
      end else if (!vld_out && !inflight) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (gap_hit) begin
        state     <= IDLE;
        cnt       <= '0;
        pkt_abort <= 1'b1;
      end else if (cap) begin
        unique case (state)
          IDLE: begin
            hdr_len    <= data_out[7:2];
            hdr_addr   <= data_out[1:0];
            hdr_valid  <= 1'b1;
            parity_acc <= data_out;
            cnt        <= '0;
            state      <= (data_out[7:2] != 6'd0) ? PAYLOAD : PARITY;
          end
          PAYLOAD: begin
            parity_acc <= parity_acc ^ data_out;
            cnt        <= cnt + 6'd1;
            if (last_byte) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            pkt_done <= 1'b1;
            pkt_err  <= (data_out != parity_acc);
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_dst_reader.sv
// Scoreboard bench for router_dst_reader: a router FIFO model feeds bytes,
// expected payload/header/done records are queued and matched on output.
module tb_router_dst_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       m_ready = 1'b0;
  logic       read_enb;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       hdr_valid;
  logic [5:0] hdr_len;
  logic [1:0] hdr_addr;
  logic       pkt_done;
  logic       pkt_err;
  logic       pkt_abort;
  logic       stall_warn;

  logic [7:0] rq[$];
  logic [8:0] exp_q[$];
  logic [7:0] hdr_q[$];
  logic       done_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int hdr_cnt = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  router_dst_reader dut (
    .clock     (clock),
    .reset     (reset),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .read_enb  (read_enb),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .hdr_valid (hdr_valid),
    .hdr_len   (hdr_len),
    .hdr_addr  (hdr_addr),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err),
    .pkt_abort (pkt_abort),
    .stall_warn(stall_warn)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {read_enb, m_valid, m_data, m_last, hdr_valid, hdr_len,
            hdr_addr, pkt_done, pkt_err, pkt_abort, stall_warn};
  endfunction

  // Router output FIFO: a fire at edge N presents its byte during cycle N+1.
  initial begin
    logic f;
    forever begin
      @(negedge clock);
      f = read_enb && vld_out;
      @(posedge clock);
      #1;
      if (f && rq.size() != 0) data_out = rq.pop_front();
      vld_out = (rq.size() != 0);
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clock);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("m_extra", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("m_byte", {23'd0, m_last, m_data}, {23'd0, e});
        end
      end
      if (hdr_valid) begin
        hdr_cnt++;
        if (hdr_q.size() == 0) check("hdr_extra", hdr_q.size(), 1);
        else check("hdr", {24'd0, hdr_len, hdr_addr},
                   {24'd0, hdr_q.pop_front()});
      end
      if (pkt_done) begin
        done_cnt++;
        if (done_q.size() == 0) check("done_extra", done_q.size(), 1);
        else check("pkt_err", pkt_err, done_q.pop_front());
      end
      if (pkt_abort) abort_cnt++;
    end
  end

  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr,
                          input logic [7:0] base, input logic [7:0] step,
                          input bit bad, input int keep);
    logic [7:0] h;
    logic [7:0] p;
    logic [7:0] b;
    h = {len, addr};
    p = h;
    rq.push_back(h);
    hdr_q.push_back(h);
    for (int i = 0; i < int'(len); i++) begin
      b = base + step * 8'(i);
      p = p ^ b;
      if (i < keep) rq.push_back(b);
      if (keep == int'(len))
        exp_q.push_back({(i == int'(len) - 1), b});
    end
    if (keep == int'(len)) begin
      rq.push_back(p ^ {7'd0, bad});
      done_q.push_back(bad);
    end
  endtask

  function automatic int left();
    return rq.size() + exp_q.size() + hdr_q.size() + done_q.size();
  endfunction

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (left() != 0 && n < max) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    check(tag, left(), 0);
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #2;
  endtask

  initial begin
    int n;
    int h0;
    int d0;
    int a0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outs", outs(), 0);
    drive_edge();
    reset = 1'b0;
    m_ready = 1'b1;

    send_pkt(6'd3, 2'd1, 8'h11, 8'h11, 1'b0, 3);
    drain("t1_drain", 100);

    send_pkt(6'd3, 2'd1, 8'h11, 8'h11, 1'b1, 3);
    drain("t2_drain", 100);

    drive_edge();
    m_ready = 1'b0;
    send_pkt(6'd8, 2'd2, 8'hA0, 8'h03, 1'b0, 8);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(vld_out && !read_enb) && n < 50);
    check("t3_stall_seen", {31'd0, vld_out && !read_enb}, 1);
    n = 0;
    while (!stall_warn && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("t3_stall_cycles", n, 25);
    check("t3_rq_left", rq.size(), 7);
    check("t3_read_enb", read_enb, 0);
    drive_edge();
    m_ready = 1'b1;
    drain("t3_drain", 200);
    check("t3_warn_clear", stall_warn, 0);

    send_pkt(6'd0, 2'd0, 8'h00, 8'h00, 1'b0, 0);
    drain("t4_drain", 100);

    h0 = hdr_cnt;
    d0 = done_cnt;
    send_pkt(6'd2, 2'd3, 8'h51, 8'h10, 1'b0, 2);
    send_pkt(6'd2, 2'd0, 8'h71, 8'h01, 1'b0, 2);
    drain("t5_drain", 100);
    check("t5_hdrs", hdr_cnt - h0, 2);
    check("t5_dones", done_cnt - d0, 2);

    drive_edge();
    m_ready = 1'b0;
    a0 = abort_cnt;
    d0 = done_cnt;
    send_pkt(6'd5, 2'd1, 8'h30, 8'h01, 1'b0, 2);
    n = 0;
    while (abort_cnt == a0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    check("t6_abort", abort_cnt - a0, 1);
    @(negedge clock);
    check("t6_skid_empty", m_valid, 0);
    check("t6_no_done", done_cnt - d0, 0);
    drive_edge();
    m_ready = 1'b1;
    send_pkt(6'd1, 2'd2, 8'h5A, 8'h00, 1'b0, 1);
    drain("t6_recover", 100);

    drive_edge();
    m_ready = 1'b0;
    send_pkt(6'd4, 2'd2, 8'h40, 8'h01, 1'b0, 4);
    n = 0;
    while (hdr_q.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check("t7_pre_valid", m_valid, 1);
    drive_edge();
    reset = 1'b1;
    rq.delete();
    exp_q.delete();
    hdr_q.delete();
    done_q.delete();
    @(posedge clock);
    @(negedge clock);
    check("t7_reset_outs", outs(), 0);
    drive_edge();
    reset = 1'b0;
    m_ready = 1'b1;
    send_pkt(6'd2, 2'd1, 8'hC3, 8'h11, 1'b0, 2);
    drain("t7_after", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
